// File: rtl/spwm_cfg_loader.sv
// spwm_cfg_loader: pulls SPWM configuration frames byte by byte from a FIFO,
// stages each channel record, reduces the carrier phase modulo TRI_PERIOD
// and then commits the masked channels in one cycle.
// Optional trailing checksum byte: define SPWM_CFG_CKSUM_EN.

module spwm_cfg_ch #(
    parameter int CYCLE_W = 16,
    parameter int PHASE_W = 10,
    parameter int TRI_W   = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ld,
    input  logic [CYCLE_W-1:0] cyc_d,
    input  logic [PHASE_W-1:0] sin_d,
    input  logic [TRI_W-1:0]   tri_d,
    output logic [CYCLE_W-1:0] cyc_q,
    output logic [PHASE_W-1:0] sin_q,
    output logic [TRI_W-1:0]   tri_q
);
    // Committed channel registers: move only on this channel's commit strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_q <= '0;
            sin_q <= '0;
            tri_q <= '0;
        end else if (ld) begin
            cyc_q <= cyc_d;
            sin_q <= sin_d;
            tri_q <= tri_d;
        end
    end
endmodule

module spwm_cfg_loader #(
    parameter int N_CH       = 3,
    parameter int CYCLE_W    = 16,
    parameter int PHASE_W    = 10,
    parameter int TRI_PERIOD = 50,
    parameter int TIMEOUT    = 1024,
    localparam int TRI_W     = $clog2(TRI_PERIOD)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [7:0]                rdfifo_data,
    input  logic                      rdfifo_empty,
    output logic                      rdfifo_req,
    output logic [N_CH*CYCLE_W-1:0]   cycle_o,
    output logic [N_CH*PHASE_W-1:0]   phase_sin_o,
    output logic [N_CH*TRI_W-1:0]     phase_tri_o,
    output logic [N_CH-1:0]           ch_en_o,
    output logic                      refresh,
    output logic                      frame_err,
    output logic                      busy
);
    localparam int CB     = (CYCLE_W + 7) / 8;
    localparam int PB     = (PHASE_W + 7) / 8;
    localparam int REC_N  = CB + PB;
    localparam int BODY_N = 1 + N_CH * REC_N;    // mask + channel records
`ifdef SPWM_CFG_CKSUM_EN
    localparam int REQ_N  = BODY_N + 1;
`else
    localparam int REQ_N  = BODY_N;
`endif
    localparam int TO_W   = $clog2(TIMEOUT + 1);
    localparam logic [7:0] HDR_BYTE = 8'hA5;

    typedef enum logic [2:0] {IDLE, HDR, BODY, CKSUM, REDUCE, COMMIT} state_t;

    state_t             state_q, state_d;
    logic               rd_vld;              // a requested byte is on rdfifo_data
    logic [6:0]         req_cnt;             // body bytes requested so far
    logic [6:0]         rx_cnt;              // body bytes received so far
    logic [TO_W-1:0]    to_cnt;
    logic [3:0]         ch_idx;
    logic [2:0]         off;
    logic [N_CH-1:0]    mask_q;
    logic [CYCLE_W-1:0] stg_cyc [N_CH];
    logic [PHASE_W-1:0] stg_ph  [N_CH];
    logic [PHASE_W-1:0] stg_tri [N_CH];      // working copy reduced in REDUCE
`ifdef SPWM_CFG_CKSUM_EN
    logic [7:0]         sum_q;
`endif

    logic       reading, hdr_hit, last_body, to_hit, cksum_bad, red_hit, commit;
    logic [3:0] red_idx;

    assign reading   = (state_q == HDR) || (state_q == BODY) || (state_q == CKSUM);
    assign hdr_hit   = (state_q == HDR) && rd_vld && (rdfifo_data == HDR_BYTE);
    assign last_body = (state_q == BODY) && rd_vld && (rx_cnt == 7'(BODY_N - 1));
    assign to_hit    = reading && rdfifo_empty && !rd_vld && (to_cnt == TO_W'(TIMEOUT - 1));
    assign commit    = (state_q == COMMIT);
`ifdef SPWM_CFG_CKSUM_EN
    assign cksum_bad = (state_q == CKSUM) && rd_vld && (rdfifo_data != sum_q);
`else
    assign cksum_bad = 1'b0;
`endif

    // Lowest-index staged phase still at or above the carrier period
    always_comb begin
        red_hit = 1'b0;
        red_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (int'(stg_tri[i]) >= TRI_PERIOD) begin
                red_hit = 1'b1;
                red_idx = 4'(i);
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state and strobes; in HDR reads run ahead because the byte
    // after a header is always the mask, so no byte is ever over-read
    always_comb begin
        state_d    = state_q;
        rdfifo_req = 1'b0;
        refresh    = 1'b0;
        frame_err  = 1'b0;
        busy       = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (!rdfifo_empty) state_d = HDR;
            end
            HDR: begin
                rdfifo_req = !rdfifo_empty;
                if (to_hit) begin
                    frame_err = 1'b1;
                    state_d   = IDLE;
                end else if (hdr_hit) begin
                    state_d = BODY;
                end
            end
            BODY: begin
                rdfifo_req = !rdfifo_empty && (req_cnt < 7'(REQ_N));
                if (to_hit) begin
                    frame_err = 1'b1;
                    state_d   = IDLE;
                end else if (last_body) begin
`ifdef SPWM_CFG_CKSUM_EN
                    state_d = CKSUM;
`else
                    state_d = REDUCE;
`endif
                end
            end
            CKSUM: begin
                rdfifo_req = !rdfifo_empty && (req_cnt < 7'(REQ_N));
                if (to_hit || cksum_bad) begin
                    frame_err = 1'b1;
                    state_d   = IDLE;
                end else if (rd_vld) begin
                    state_d = REDUCE;
                end
            end
            REDUCE: begin
                if (!red_hit) state_d = COMMIT;
            end
            COMMIT: begin
                refresh = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Byte capture, staging, timeout and modulo reduction
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_vld  <= 1'b0;
            req_cnt <= '0;
            rx_cnt  <= '0;
            to_cnt  <= '0;
            ch_idx  <= '0;
            off     <= '0;
            mask_q  <= '0;
            ch_en_o <= '0;
`ifdef SPWM_CFG_CKSUM_EN
            sum_q   <= '0;
`endif
            for (int i = 0; i < N_CH; i++) begin
                stg_cyc[i] <= '0;
                stg_ph[i]  <= '0;
                stg_tri[i] <= '0;
            end
        end else begin
            rd_vld <= rdfifo_req;
            if (!reading || rd_vld || !rdfifo_empty) to_cnt <= '0;
            else                                     to_cnt <= to_cnt + TO_W'(1);
            case (state_q)
                HDR: begin
                    // the request issued alongside the header is the mask byte
                    req_cnt <= (hdr_hit && rdfifo_req) ? 7'd1 : 7'd0;
                    rx_cnt  <= '0;
                    ch_idx  <= '0;
                    off     <= '0;
                    mask_q  <= '0;
`ifdef SPWM_CFG_CKSUM_EN
                    sum_q   <= '0;
`endif
                end
                BODY: begin
                    if (rdfifo_req) req_cnt <= req_cnt + 7'd1;
                    if (rd_vld) begin
                        rx_cnt <= rx_cnt + 7'd1;
`ifdef SPWM_CFG_CKSUM_EN
                        sum_q  <= sum_q + rdfifo_data;
`endif
                        if (rx_cnt == 7'd0) begin
                            mask_q <= rdfifo_data[N_CH-1:0];
                        end else begin
                            // MSB-first shift; truncation drops excess high bits
                            for (int i = 0; i < N_CH; i++) begin
                                if (ch_idx == 4'(i)) begin
                                    if (int'(off) < CB) begin
                                        stg_cyc[i] <= CYCLE_W'({stg_cyc[i], rdfifo_data});
                                    end else begin
                                        stg_ph[i]  <= PHASE_W'({stg_ph[i], rdfifo_data});
                                        stg_tri[i] <= PHASE_W'({stg_ph[i], rdfifo_data});
                                    end
                                end
                            end
                            if (off == 3'(REC_N - 1)) begin
                                off    <= '0;
                                ch_idx <= ch_idx + 4'd1;
                            end else begin
                                off <= off + 3'd1;
                            end
                        end
                    end
                end
                CKSUM: begin
                    if (rdfifo_req) req_cnt <= req_cnt + 7'd1;
                end
                REDUCE: begin
                    for (int i = 0; i < N_CH; i++) begin
                        if (red_hit && red_idx == 4'(i))
                            stg_tri[i] <= stg_tri[i] - PHASE_W'(TRI_PERIOD);
                    end
                end
                COMMIT: begin
                    ch_en_o <= mask_q;
                end
                default: ;
            endcase
            // an aborted frame leaves nothing committable behind
            if (frame_err) mask_q <= '0;
        end
    end

    // Per-channel committed registers
    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [TRI_W-1:0] tri_d;
        assign tri_d = TRI_W'(stg_tri[g]);
        spwm_cfg_ch #(
            .CYCLE_W (CYCLE_W),
            .PHASE_W (PHASE_W),
            .TRI_W   (TRI_W)
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .ld    (commit && mask_q[g]),
            .cyc_d (stg_cyc[g]),
            .sin_d (stg_ph[g]),
            .tri_d (tri_d),
            .cyc_q (cycle_o[g*CYCLE_W +: CYCLE_W]),
            .sin_q (phase_sin_o[g*PHASE_W +: PHASE_W]),
            .tri_q (phase_tri_o[g*TRI_W +: TRI_W])
        );
    end
endmodule
